// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and the
// width helper used to size the baud and bit counters.
package uart_pkg;

  // Transmit FSM states. ST_PARITY is only entered when parity is enabled.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Bits needed to hold the values 0..value-1, never less than 1.
  function automatic int clogb2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while enabled and raises tc
// during the last cycle of each bit period. clr returns the count to 0.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CW = clogb2(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  assign tc = en && (cnt_q == LAST);

  // Count register: clear dominates, wraps to 0 at the end of each bit period.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + 1'b1;
    end
  end

endmodule : uart_baud_gen

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATAWIDTH data bits LSB first, optional even
// parity bit, one stop bit. Every line bit lasts CLK_FREQ/BAUDRATE clocks.
// Optional feature macro: UART_TX_PARITY_EN (adds the even parity bit).
//
// Handshake: a byte is accepted on a rising edge where tx_valid and tx_ready
// are both high. tx_ready is high only in IDLE; tx_valid seen in any other
// state is ignored, never queued. The line drops to the start bit in the
// first cycle after the accepting edge.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int BAUDRATE  = 9600,
  parameter int CLK_FREQ  = 50000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUDRATE;
  localparam int BCW        = clogb2(DATAWIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATAWIDTH - 1);

  // State is kept in a named register so checkers can observe it directly.
  uart_state_e          state_q, state_d;
  logic [DATAWIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 txd_q, txd_d;
  logic                 baud_tc;
  logic                 baud_clr;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // The bit timer restarts from 0 on every state change and is idle in IDLE.
  assign baud_clr = (state_d != state_q);

  uart_baud_gen #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .en  (state_q != ST_IDLE),
    .clr (baud_clr),
    .tc  (baud_tc)
  );

  assign tx_ready = (state_q == ST_IDLE);
  assign tx_busy  = (state_q != ST_IDLE);
  assign tx_done  = (state_q == ST_STOP) && baud_tc;
  assign txd      = txd_q;

  // Next-state, datapath and next line level; txd is derived from the next
  // state so the registered line changes on the same edge as the FSM.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d = ST_START;
          shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (baud_tc) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (baud_tc) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_tc) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (baud_tc) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    txd_d = 1'b1;
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the payload captured at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLK_FREQ=160, BAUDRATE=10 (16 clocks
// per bit). A frame-level model predicts every output each cycle; a line
// receiver decodes txd and checks decoded bytes against the expected queue.
module tb_uart_tx;

  localparam int BC = 16;
  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS = DW + 2 + PB;
  localparam int FLEN  = NBITS * BC;

  logic          clk;
  logic          rst;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          txd;
  logic          tx_busy;
  logic          tx_done;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx #(
    .DATAWIDTH (DW),
    .BAUDRATE  (10),
    .CLK_FREQ  (160)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .txd      (txd),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: the line is a list of NBITS levels, each held BC clocks.
  logic [NBITS-1:0] m_frame;
  int               m_pos = -1;
  logic             model_live = 1'b0;
  logic             rx_abort = 1'b0;
  logic [DW-1:0]    exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_pos = -1;
      exp_q.delete();
      rx_abort = 1'b1;
    end else if (m_pos < 0) begin
      if (tx_valid) begin
        m_frame = '0;
        m_frame[0] = 1'b0;
        for (int i = 0; i < DW; i++) m_frame[1+i] = tx_data[i];
`ifdef UART_TX_PARITY_EN
        m_frame[DW+1] = ^tx_data;
`endif
        m_frame[NBITS-1] = 1'b1;
        exp_q.push_back(tx_data);
        m_pos = 0;
      end
    end else begin
      m_pos = m_pos + 1;
      if (m_pos == FLEN) m_pos = -1;
    end
    model_live = 1'b1;
  end

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    logic [3:0] e;
    if (model_live) begin
      if (m_pos < 0) e = 4'b1100;
      else e = {m_frame[m_pos / BC], 1'b0, 1'b1, (m_pos == FLEN - 1)};
      check("cycle {txd,ready,busy,done}", {28'd0, txd, tx_ready, tx_busy, tx_done}, {28'd0, e});
    end
  end

  // Line receiver: samples mid-bit and scores decoded bytes against exp_q.
  logic          rx_act = 1'b0;
  int            rx_t;
  logic [DW-1:0] rx_byte;
  logic [DW-1:0] last_rx = '0;
  logic          last_par = 1'b0;

  always @(negedge clk) begin
    int bi;
    if (rx_abort) begin
      rx_act = 1'b0;
      rx_abort = 1'b0;
    end else if (!rx_act) begin
      if (model_live && txd === 1'b0) begin
        rx_act = 1'b1;
        rx_t = 0;
        rx_byte = '0;
      end
    end else begin
      rx_t++;
      if (rx_t % BC == BC / 2) begin
        bi = rx_t / BC;
        if (bi >= 1 && bi <= DW) rx_byte[bi-1] = txd;
        if (PB == 1 && bi == DW + 1) last_par = txd;
        if (bi == NBITS - 1) begin
          check("rx stop bit", {31'd0, txd}, 32'd1);
          if (exp_q.size() == 0) begin
            check("rx unexpected frame", 32'd1, 32'd0);
          end else begin
            check("rx byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
          end
          last_rx = rx_byte;
          rx_act = 1'b0;
        end
      end
    end
  end

  // Driver: waits for IDLE, sends one byte, captures the line, returns the
  // number of cycles from the accepting edge to the tx_done pulse.
  int   cap[0:399];
  logic first_txd;

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (!tx_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (!tx_ready) check("wait_idle timeout", 32'd1, 32'd0);
  endtask

  task automatic send_byte(input logic [DW-1:0] d, input bit noise, output int lat);
    int n;
    wait_idle();
    tx_data = d;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    first_txd = txd;
    cap[0] = txd;
    n = 1;
    while (!tx_done && n < 399) begin
      if (noise && n > 4 && n < FLEN - 20) begin
        tx_data = DW'($urandom);
        tx_valid = ($urandom_range(0, 3) == 0);
      end else begin
        tx_valid = 1'b0;
      end
      @(negedge clk);
      cap[n] = txd;
      n++;
    end
    tx_valid = 1'b0;
    lat = tx_done ? n : -1;
  endtask

  initial begin
    int lat, ok, n, first_rdy, done1, done2, rdy_cnt, dcnt;
    logic [NBITS-1:0] line;

    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: outputs must stay idle for 50 clocks.
    ok = 0;
    repeat (50) begin
      @(negedge clk);
      if (txd && tx_ready && !tx_busy && !tx_done) ok++;
    end
    check("idle 50 clocks", ok, 32'd50);

    // 0xA5 frame: latency, per-bit levels and done timing.
    send_byte(8'hA5, 1'b0, lat);
    check("A5 first cycle txd", {31'd0, first_txd}, 32'd0);
    check("A5 done latency", lat, FLEN);
    for (int b = 0; b < NBITS; b++) line[b] = cap[b * BC + BC / 2][0];
`ifdef UART_TX_PARITY_EN
    check("A5 line bits", {21'd0, line}, {21'd0, 1'b1, 1'b0, 8'hA5, 1'b0});
`else
    check("A5 line bits", {22'd0, line}, {22'd0, 1'b1, 8'hA5, 1'b0});
`endif
    check("A5 received", {24'd0, last_rx}, 32'hA5);

    // Back-to-back with tx_valid held: one idle clock between frames.
    wait_idle();
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_data = 8'hFF;
    n = 1; first_rdy = -1; done1 = -1; done2 = -1; rdy_cnt = 0;
    while (done2 < 0 && n < 800) begin
      if (tx_ready) begin
        rdy_cnt++;
        if (first_rdy < 0) first_rdy = n;
      end
      if (tx_done) begin
        if (done1 < 0) done1 = n;
        else done2 = n;
      end
      @(negedge clk);
      n++;
      if (first_rdy >= 0) tx_valid = 1'b0;
    end
    tx_valid = 1'b0;
    check("b2b first done", done1, FLEN);
    check("b2b ready cycle", first_rdy, FLEN + 1);
    check("b2b ready count", rdy_cnt, 32'd1);
    check("b2b second done", done2, 2 * FLEN + 1);
    check("b2b last received", {24'd0, last_rx}, 32'hFF);

    // Reset at clock 70 of a 0x3C frame, with tx_valid high during reset.
    wait_idle();
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    n = 1;
    while (n < 70) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    tx_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tx_valid = 1'b0;
    check("reset txd", {31'd0, txd}, 32'd1);
    check("reset ready", {31'd0, tx_ready}, 32'd1);
    check("reset busy", {31'd0, tx_busy}, 32'd0);
    dcnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_done || tx_busy) dcnt++;
    end
    check("no resume after reset", dcnt, 32'd0);

    // 0x55 with tx_data churn and tx_valid pulses mid-frame.
    send_byte(8'h55, 1'b1, lat);
    check("55 done latency", lat, FLEN);
    check("55 received", {24'd0, last_rx}, 32'h55);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_busy) dcnt++;
    end
    check("55 no second frame", dcnt, 32'd0);

`ifdef UART_TX_PARITY_EN
    send_byte(8'h07, 1'b0, lat);
    check("07 frame length", lat, 32'd176);
    check("07 parity", {31'd0, last_par}, 32'd1);
    send_byte(8'h03, 1'b0, lat);
    check("03 parity", {31'd0, last_par}, 32'd0);
`endif

    // Randomized frames with random gaps.
    for (int f = 0; f < 15; f++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send_byte(DW'($urandom), ($urandom_range(0, 1) == 1), lat);
      check("random done latency", lat, FLEN);
    end

    repeat (30) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_uart_tx

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, number of payload bits per frame (1..16).
REQ-002 SHALL have parameter BAUDRATE, default 9600, line bit rate in bit/s.
REQ-003 SHALL have parameter CLK_FREQ, default 50000000, clk frequency in Hz.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port tx_data  input  DATAWIDTH  payload to send, LSB first.
REQ-007 SHALL have port tx_valid  input  1  producer has a byte on tx_data.
REQ-008 SHALL have port tx_ready  output  1  block can accept a byte this cycle.
REQ-009 SHALL have port txd  output  1  serial line, idle high.
REQ-010 SHALL have port tx_busy  output  1  frame in progress.
REQ-011 SHALL have port tx_done  output  1  one-cycle pulse at end of stop bit.

Function
REQ-012 SHALL define BIT_CYCLES = CLK_FREQ/BAUDRATE (integer division); every line bit SHALL last exactly BIT_CYCLES clocks.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-014 IDLE: txd=1, tx_ready=1, tx_busy=0; handshake = tx_valid & tx_ready at a rising edge.
REQ-015 On handshake SHALL latch tx_data into a shift register and enter START; txd SHALL go 0 in the first cycle after the handshake edge (latency 1 clock).
REQ-016 tx_data changes after the handshake SHALL NOT affect the frame in progress.
REQ-017 START -> DATA after BIT_CYCLES; DATA SHALL drive bit 0 first and shift once per bit, DATAWIDTH bits total, tracked by a bit counter wrapping to 0 on exit.
REQ-018 DATA -> PARITY (macro defined) or STOP after last data bit; STOP drives txd=1 for BIT_CYCLES.
REQ-019 At last cycle of STOP: tx_done=1 for exactly that cycle; next cycle IDLE with tx_ready=1.
REQ-020 tx_ready SHALL be 0 in every non-IDLE state; tx_valid there SHALL be ignored, not queued.
REQ-021 Back-to-back: with tx_valid held high, the next frame SHALL be accepted in the single IDLE cycle after STOP, giving exactly one idle-high clock between frames.
REQ-022 Baud counter SHALL count 0..BIT_CYCLES-1, reset to 0 on every state change, and not run in IDLE.
REQ-023 txd SHALL be driven from a register (glitch-free).

Reset
REQ-024 rst=1 at any edge, including mid-frame, SHALL force IDLE, txd=1, tx_ready=1 the following cycle and all other outputs 0, counters and shift register 0.
REQ-025 A frame interrupted by reset SHALL NOT resume; tx_valid during rst SHALL be ignored.

Configuration
REQ-026 Macro UART_TX_PARITY_EN: when defined, SHALL insert one PARITY bit after data equal to even parity (XOR of the latched payload bits), duration BIT_CYCLES.
REQ-027 Without UART_TX_PARITY_EN, SHALL produce 8N1-style frames (start, DATAWIDTH data, one stop) and contain no parity logic.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state encoding and the clogb2 width function used for counter widths.
REQ-029 Baud timing SHALL be one sub-module uart_baud_gen (counter with enable, clear and terminal-count pulse); all else in uart_tx.

Verification (CLK_FREQ=160, BAUDRATE=10 -> BIT_CYCLES=16)
REQ-030 Reset then idle 50 clocks -> txd=1, tx_ready=1, tx_busy=0, tx_done=0 throughout.
REQ-031 Send 0xA5 -> txd 0 for 16 clocks, then 1,0,1,0,0,1,0,1 at 16 clocks each, then 1 for 16; tx_done pulse at clock 160 after handshake; frame start 1 clock after handshake.
REQ-032 tx_valid held high, bytes 0x00 then 0xFF -> two correct frames, exactly one idle-high clock between them, tx_ready high only in that cycle.
REQ-033 Assert rst at clock 70 of a 0x3C frame -> next cycle txd=1, tx_ready=1, tx_busy=0; no tx_done pulse.
REQ-034 With UART_TX_PARITY_EN, send 0x07 -> parity bit 1 after bit 7, frame length 176 clocks; 0x03 -> parity 0.
REQ-035 Change tx_data and pulse tx_valid during a frame of 0x55 -> line still shows 0x55; no second frame starts.
